// File: rtl/board_renderer_if.sv
// Pixel/game-state bundle between the VGA timing side and the board colouriser.
// Latency: none (wires only).
// Backpressure: none; the raster streams one pixel per clock.
interface board_renderer_if #(
    parameter int N_COLS = 7,
    parameter int N_ROWS = 6
);
    logic [9:0]                 pixel_x;
    logic [9:0]                 pixel_y;
    logic                       hsync_in;
    logic                       vsync_in;
    logic                       frame_start;
    logic [2*N_COLS*N_ROWS-1:0] panel;
    logic [N_COLS-1:0]          play;
    logic                       turn;
    logic                       game_over;
    logic [N_COLS*N_ROWS-1:0]   win_mask;
    logic [3:0]                 data_red;
    logic [3:0]                 data_green;
    logic [3:0]                 data_blue;
    logic                       hsync_out;
    logic                       vsync_out;

    // Source side: timing generator plus game logic, consuming the colour.
    modport master (
        output pixel_x, pixel_y, hsync_in, vsync_in, frame_start,
        output panel, play, turn, game_over, win_mask,
        input  data_red, data_green, data_blue, hsync_out, vsync_out
    );

    // Renderer side.
    modport slave (
        input  pixel_x, pixel_y, hsync_in, vsync_in, frame_start,
        input  panel, play, turn, game_over, win_mask,
        output data_red, data_green, data_blue, hsync_out, vsync_out
    );
endinterface

// File: rtl/board_renderer.sv
// Score-4 board colouriser: maps raster position + game state to 4-bit RGB.
// Latency: 2 cycles from pixel_x/pixel_y to RGB; syncs delayed to match.
// Backpressure: none; accepts one pixel every clock unconditionally.
module board_renderer #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int N_COLS       = 7,
    parameter int N_ROWS       = 6,
    parameter int CELL         = 40,
    parameter int GAP          = 30,
    parameter int X_MARGIN     = 90,
    parameter int TOP_MARGIN   = 20,
    parameter int SEL_GAP      = 20,
    parameter int SEL_H        = 20,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    board_renderer_if.slave    vga
);
    localparam int PITCH = CELL + GAP;
    localparam int GY1   = TOP_MARGIN + N_ROWS*CELL + (N_ROWS-1)*GAP;
    localparam int SY0   = GY1 + SEL_GAP;
    localparam int SY1   = SY0 + SEL_H;
    localparam int CW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int RW    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int FCW   = $clog2(BLINK_FRAMES) + 1;

    localparam logic [11:0] RGB_BLACK = 12'h000;
    localparam logic [11:0] RGB_RED   = 12'hF00;
    localparam logic [11:0] RGB_GREEN = 12'h0F0;
    localparam logic [11:0] RGB_BLUE  = 12'h00F;
    localparam logic [11:0] RGB_WHITE = 12'hFFF;

    // Raster position widened so every bound compares at 32 bits.
    logic [31:0] xw;
    logic [31:0] yw;
    assign xw = {22'd0, vga.pixel_x};
    assign yw = {22'd0, vga.pixel_y};

    // Stage-1 combinational decode.
    logic          col_hit_d;
    logic          row_hit_d;
    logic [CW-1:0] col_idx_d;
    logic [RW-1:0] row_idx_d;
    logic          off_d;
    logic          border_d;
    logic          bar_d;

    // Stage-1 registers.
    logic          s1_vld;
    logic          s1_off;
    logic          s1_border;
    logic          s1_bar;
    logic          s1_col_hit;
    logic          s1_row_hit;
    logic [CW-1:0] s1_col;
    logic [RW-1:0] s1_row;

    // Stage-2 lookup.
    logic [1:0]    cell_code;
    logic          cell_win;
    logic          col_sel;
    logic [11:0]   rgb_d;
    logic [11:0]   rgb_q;

    // Blink state.
    logic [FCW-1:0] frame_cnt;
    logic           blink_phase;

    // Sync delay line.
    logic [1:0] hs_sr;
    logic [1:0] vs_sr;

    // Column hit: unrolled compare against constant per-column windows.
    always_comb begin
        col_hit_d = 1'b0;
        col_idx_d = '0;
        for (int i = 0; i < N_COLS; i++) begin
            if (xw >= X_MARGIN + i*PITCH && xw < X_MARGIN + i*PITCH + CELL) begin
                col_hit_d = 1'b1;
                col_idx_d = CW'(i);
            end
        end
    end

    // Row hit: same scheme against constant per-row windows.
    always_comb begin
        row_hit_d = 1'b0;
        row_idx_d = '0;
        for (int j = 0; j < N_ROWS; j++) begin
            if (yw >= TOP_MARGIN + j*PITCH && yw < TOP_MARGIN + j*PITCH + CELL) begin
                row_hit_d = 1'b1;
                row_idx_d = RW'(j);
            end
        end
    end

    // Region flags: off-screen, blue border frame, selector bar strip.
    always_comb begin
        off_d    = (xw >= H_ACTIVE) || (yw >= V_ACTIVE);
        border_d = (xw < X_MARGIN) || (xw >= H_ACTIVE - X_MARGIN) ||
                   (yw < TOP_MARGIN) || (yw >= GY1 && yw < SY0) ||
                   (yw >= SY1);
        bar_d    = (yw >= SY0) && (yw < SY1);
    end

    // Stage 1: register decoded geometry; valid clears on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s1_off     <= 1'b0;
            s1_border  <= 1'b0;
            s1_bar     <= 1'b0;
            s1_col_hit <= 1'b0;
            s1_row_hit <= 1'b0;
            s1_col     <= '0;
            s1_row     <= '0;
        end else begin
            s1_vld     <= 1'b1;
            s1_off     <= off_d;
            s1_border  <= border_d;
            s1_bar     <= bar_d;
            s1_col_hit <= col_hit_d;
            s1_row_hit <= row_hit_d;
            s1_col     <= col_idx_d;
            s1_row     <= row_idx_d;
        end
    end

    // Stage-2 state lookup: mux the addressed cell, win bit and play bit.
    always_comb begin
        cell_code = 2'b00;
        cell_win  = 1'b0;
        col_sel   = 1'b0;
        for (int i = 0; i < N_COLS; i++) begin
            if (s1_col == CW'(i)) begin
                col_sel = vga.play[i];
            end
            for (int j = 0; j < N_ROWS; j++) begin
                if (s1_col == CW'(i) && s1_row == RW'(j)) begin
                    cell_code = vga.panel[2*(i*N_ROWS+j) +: 2];
                    cell_win  = vga.win_mask[i*N_ROWS+j];
                end
            end
        end
    end

    // Colour priority: off-screen, border, selector bar, cell, background.
    always_comb begin
        rgb_d = RGB_BLACK;
        if (!s1_vld || s1_off) begin
            rgb_d = RGB_BLACK;
        end else if (s1_border) begin
            rgb_d = RGB_BLUE;
        end else if (s1_bar) begin
            if (s1_col_hit && col_sel && !vga.game_over) begin
                rgb_d = vga.turn ? RGB_GREEN : RGB_RED;
            end
        end else if (s1_col_hit && s1_row_hit) begin
            if (vga.game_over && cell_win && blink_phase) begin
                rgb_d = RGB_WHITE;
            end else if (cell_code == 2'b01) begin
                rgb_d = RGB_RED;
            end else if (cell_code == 2'b10) begin
                rgb_d = RGB_GREEN;
            end
        end
    end

    // Stage 2: register the final colour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q <= RGB_BLACK;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    // Blink timer: counts frames only while the win is displayed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!vga.game_over) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (vga.frame_start) begin
            if (frame_cnt == FCW'(BLINK_FRAMES-1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt   <= frame_cnt + 1'b1;
            end
        end
    end

    // Syncs ride a 2-deep shift register to stay aligned with the RGB; idle high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_sr <= 2'b11;
            vs_sr <= 2'b11;
        end else begin
            hs_sr <= {hs_sr[0], vga.hsync_in};
            vs_sr <= {vs_sr[0], vga.vsync_in};
        end
    end

    assign vga.data_red   = rgb_q[11:8];
    assign vga.data_green = rgb_q[7:4];
    assign vga.data_blue  = rgb_q[3:0];
    assign vga.hsync_out  = hs_sr[1];
    assign vga.vsync_out  = vs_sr[1];
endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: vector table plus latency, sync, blink and reset sequences.
// Latency: checks RGB exactly 2 clocks after the pixel is driven.
// Backpressure: n/a.
module tb_board_renderer;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    board_renderer_if #(.N_COLS(7), .N_ROWS(6)) vif ();

    board_renderer #(.BLINK_FRAMES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vif.slave)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [6:0]  play;
        logic        turn;
        logic        go;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int x, input int y, input logic [6:0] pl,
                       input logic tn, input logic go, input logic [11:0] e);
        vec_t v;
        v.x = 10'(x); v.y = 10'(y); v.play = pl; v.turn = tn; v.go = go; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_rgb(input string nm, input logic [11:0] e);
        logic [11:0] a;
        a = {vif.data_red, vif.data_green, vif.data_blue};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: rgb got %03h want %03h", nm, a, e);
        end
    endtask

    task automatic chk_bit(input string nm, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, a, e);
        end
    endtask

    task automatic pix(input int x, input int y);
        vif.pixel_x = 10'(x);
        vif.pixel_y = 10'(y);
    endtask

    task automatic pulse_frame();
        vif.frame_start = 1'b1;
        tick(1);
        vif.frame_start = 1'b0;
        tick(2);
    endtask

    logic [83:0] panel_v;
    logic        hq[$];
    logic        vq[$];

    initial begin
        // Fixed board: (0,0)=01, (2,1)=01, (3,2)=10, (4,0)=11.
        panel_v = '0;
        panel_v[1:0]   = 2'b01;
        panel_v[27:26] = 2'b01;
        panel_v[41:40] = 2'b10;
        panel_v[49:48] = 2'b11;

        add(130, 40,  7'b0000000, 1'b0, 1'b0, 12'h000); // gap right of cell (0,0)
        add(50,  100, 7'b0000000, 1'b0, 1'b0, 12'h00F); // left border
        add(300, 420, 7'b0000000, 1'b0, 1'b0, 12'h00F); // grid-to-selector strip
        add(700, 100, 7'b0000000, 1'b0, 1'b0, 12'h000); // off-screen
        add(300, 440, 7'b0001000, 1'b1, 1'b0, 12'h0F0); // bar col 3, player 1
        add(340, 440, 7'b0001000, 1'b1, 1'b0, 12'h000); // bar gap
        add(300, 440, 7'b0001000, 1'b1, 1'b1, 12'h000); // bar hidden after game over
        add(300, 440, 7'b0001000, 1'b0, 1'b0, 12'hF00); // bar col 3, player 0
        add(230, 90,  7'b0000000, 1'b0, 1'b0, 12'hF00); // cell (2,1)
        add(310, 170, 7'b0000000, 1'b0, 1'b0, 12'h0F0); // cell (3,2)
        add(380, 30,  7'b0000000, 1'b0, 1'b0, 12'h000); // cell (4,0) code 11
        add(129, 59,  7'b0000000, 1'b0, 1'b0, 12'hF00); // last pixel inside (0,0)
        add(110, 60,  7'b0000000, 1'b0, 1'b0, 12'h000); // row edge exclusive
        add(89,  40,  7'b0000000, 1'b0, 1'b0, 12'h00F); // last left-border column
        add(550, 40,  7'b0000000, 1'b0, 1'b0, 12'h00F); // first right-border column
        add(640, 40,  7'b0000000, 1'b0, 1'b0, 12'h000); // x = H_ACTIVE
        add(639, 479, 7'b0000000, 1'b0, 1'b0, 12'h00F); // last visible pixel
        add(100, 449, 7'b1000001, 1'b0, 1'b0, 12'hF00); // multi-hot, col 0, bar last row
        add(520, 440, 7'b1000001, 1'b0, 1'b0, 12'hF00); // multi-hot, col 6
        add(160, 440, 7'b1000001, 1'b0, 1'b0, 12'h000); // unselected col 1
        add(110, 430, 7'b0000001, 1'b0, 1'b0, 12'hF00); // bar top row inclusive
        add(110, 450, 7'b0000001, 1'b0, 1'b0, 12'h00F); // below bar
        add(110, 429, 7'b0000001, 1'b0, 1'b0, 12'h00F); // strip just above bar

        // Reset state.
        rst_n           = 1'b0;
        vif.hsync_in    = 1'b0;
        vif.vsync_in    = 1'b0;
        vif.frame_start = 1'b0;
        vif.panel       = panel_v;
        vif.play        = '0;
        vif.turn        = 1'b0;
        vif.game_over   = 1'b0;
        vif.win_mask    = '0;
        pix(700, 100);
        tick(3);
        chk_rgb("reset_rgb", 12'h000);
        chk_bit("reset_hsync", vif.hsync_out, 1'b1);
        chk_bit("reset_vsync", vif.vsync_out, 1'b1);

        // Latency and streaming straight out of reset.
        rst_n = 1'b1;
        pix(110, 40);
        tick(1);
        chk_rgb("lat_first_cycle", 12'h000);
        pix(50, 100);
        tick(1);
        chk_rgb("lat_cell00", 12'hF00);
        pix(700, 100);
        tick(1);
        chk_rgb("lat_border", 12'h00F);
        tick(1);
        chk_rgb("lat_offscreen", 12'h000);

        // Vector table, each vector held for the full pipeline depth.
        foreach (vecs[k]) begin
            pix(int'(vecs[k].x), int'(vecs[k].y));
            vif.play      = vecs[k].play;
            vif.turn      = vecs[k].turn;
            vif.game_over = vecs[k].go;
            tick(2);
            chk_rgb($sformatf("vec%0d", k), vecs[k].exp);
        end
        vif.play      = '0;
        vif.turn      = 1'b0;
        vif.game_over = 1'b0;

        // Sync delay line.
        for (int k = 0; k < 20; k++) begin
            if (k >= 2) begin
                chk_bit($sformatf("hsync%0d", k), vif.hsync_out, hq[k-2]);
                chk_bit($sformatf("vsync%0d", k), vif.vsync_out, vq[k-2]);
            end
            vif.hsync_in = 1'($urandom_range(0, 1));
            vif.vsync_in = 1'($urandom_range(0, 1));
            hq.push_back(vif.hsync_in);
            vq.push_back(vif.vsync_in);
            tick(1);
        end

        // Blink: winning cell (0,0) owned by player 1.
        panel_v[1:0] = 2'b10;
        vif.panel    = panel_v;
        vif.win_mask = 42'd1;
        pix(110, 40);
        tick(2);
        chk_rgb("blink_pre", 12'h0F0);
        vif.game_over = 1'b1;
        tick(2);
        chk_rgb("blink_f0", 12'h0F0);
        pulse_frame(); chk_rgb("blink_f1", 12'h0F0);
        pulse_frame(); chk_rgb("blink_f2", 12'hFFF);
        pulse_frame(); chk_rgb("blink_f3", 12'hFFF);
        pulse_frame(); chk_rgb("blink_f4", 12'h0F0);
        pulse_frame(); chk_rgb("blink_f5", 12'h0F0);
        pulse_frame(); chk_rgb("blink_f6", 12'hFFF);
        vif.game_over = 1'b0;
        tick(1);
        chk_rgb("blink_drop", 12'h0F0);
        vif.game_over = 1'b1;
        tick(2);
        chk_rgb("blink_cleared", 12'h0F0);

        // Mid-blink reset: phase=1, frame_cnt=1 before the reset pulse.
        pulse_frame();
        pulse_frame(); chk_rgb("rst_mid_pre2", 12'hFFF);
        pulse_frame(); chk_rgb("rst_mid_pre3", 12'hFFF);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk_rgb("rst_mid_c0", 12'h000);
        chk_bit("rst_mid_hsync", vif.hsync_out, 1'b1);
        tick(1);
        chk_rgb("rst_mid_c1", 12'h000);
        tick(1);
        chk_rgb("rst_mid_phase0", 12'h0F0);
        pulse_frame(); chk_rgb("rst_mid_cnt0", 12'h0F0);
        pulse_frame(); chk_rgb("rst_mid_toggle", 12'hFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/board_renderer.md
Name: board_renderer

Overview:
- Pipelined, parametrised pixel colouriser for the Score-4 VGA display.
- Takes the raster position and timing syncs from the VGA timing generator, plus the game state (panel, column selector, turn, win mask).
- Produces registered 4-bit RGB, with syncs delayed to match.
- Generalises board size, cell geometry and colours, and adds a frame-counted blink of the winning cells after game over.

Parameters:
- H_ACTIVE, 640, visible columns.
- V_ACTIVE, 480, visible rows.
- N_COLS, 7, board columns.
- N_ROWS, 6, board rows.
- CELL, 40, cell edge in pixels.
- GAP, 30, spacing between cells; PITCH = CELL+GAP.
- X_MARGIN, 90, left/right border width.
- TOP_MARGIN, 20, top border height.
- SEL_GAP, 20, border strip between grid bottom and selector bar.
- SEL_H, 20, selector bar height.
- BLINK_FRAMES, 30, frames per blink half-period (≥1).

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- pixel_x  in  10  raster column.
- pixel_y  in  10  raster row.
- hsync_in  in  1  horizontal sync from timing generator.
- vsync_in  in  1  vertical sync from timing generator.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- panel  in  2*N_COLS*N_ROWS  cell (i,j) at bits [2*(i*N_ROWS+j)+:2]; 01 = player 0, 10 = player 1, else empty.
- play  in  N_COLS  one-hot selected column.
- turn  in  1  0 = player 0, 1 = player 1.
- game_over  in  1  win state active.
- win_mask  in  N_COLS*N_ROWS  bit (i*N_ROWS+j) marks a winning cell.
- data_red  out  4  red.
- data_green  out  4  green.
- data_blue  out  4  blue.
- hsync_out  out  1  hsync_in delayed 2 cycles.
- vsync_out  out  1  vsync_in delayed 2 cycles.

Behaviour:

Geometry (all ranges half-open [lo,hi)):
- Cell column i: x in [X_MARGIN+i*PITCH, X_MARGIN+i*PITCH+CELL).
- Cell row j: y in [TOP_MARGIN+j*PITCH, TOP_MARGIN+j*PITCH+CELL).
- GY1 = TOP_MARGIN + N_ROWS*CELL + (N_ROWS-1)*GAP.
- SY0 = GY1 + SEL_GAP; selector bar is y in [SY0, SY0+SEL_H).

Colour priority (first match wins):
1. x ≥ H_ACTIVE or y ≥ V_ACTIVE → 000.
2. Border → 00F. Border is any of: x < X_MARGIN, x ≥ H_ACTIVE−X_MARGIN, y < TOP_MARGIN, y in [GY1, SY0), y ≥ SY0+SEL_H.
3. Selector bar, inside column i's x-range, play[i]=1, game_over=0 → F00 if turn=0, else 0F0.
4. Cell (i,j) → colour by code: 01 → F00; 10 → 0F0; 00/11 → 000.
   - Exception: if game_over=1, win_mask bit set and blink_phase=1 → FFF.
5. Anything else (gaps, unselected bar) → 000.

Pipeline and latency:
- Stage 1 registers the region flags and the hit column/row indices.
- Stage 2 looks up state and registers the RGB.
- A pixel presented in cycle n appears on the outputs in cycle n+2.
- panel, play, turn, game_over, win_mask and blink_phase are sampled at stage 2 (cycle n+1).
- hsync/vsync pass through a 2-deep shift register, so they stay aligned with the RGB.
- Column/row index computation must not use runtime multipliers. Use parameter-derived comparisons or incremental counters.
- A multi-hot play vector lights every selected box.

Blink:
- frame_cnt is ceil(log2(BLINK_FRAMES))+1 bits wide; blink_phase is 1 bit.
- While game_over=0, both are held at 0.
- While game_over=1, on each frame_start:
  - if frame_cnt = BLINK_FRAMES−1: frame_cnt ← 0 and blink_phase toggles;
  - else frame_cnt increments.
- When game_over falls, both clear on the next edge.

Reset:
- rst_n=0 at a clock edge sets RGB = 0, hsync_out = vsync_out = 1, pipeline valid bits = 0, frame_cnt = 0, blink_phase = 0.
- Reset mid-frame: outputs are 0 until two pixels after rst_n releases, with no stale colour.

Test Plan:
- Reset, then pixel (110,40) with panel cell (0,0)=01 → RGB F00 exactly 2 cycles later; cycles in between show 000.
- Pixel (130,40) → 000 (gap, exclusive cell edge). Pixel (50,100) → 00F. Pixel (300,420) → 00F (grid-to-selector strip). Pixel (700,100) → 000.
- play=0001000, turn=1, pixel (300,440) → 0F0. Pixel (340,440) → 000. game_over=1 at the same pixel → 000.
- game_over=1, win_mask bit 0 set, cell (0,0)=10, BLINK_FRAMES=2:
  - pixel (110,40) shows 0F0 for frames 0–1, FFF for frames 2–3, 0F0 for frames 4–5;
  - dropping game_over restores 0F0 at once.
- Toggle hsync_in/vsync_in → each output follows with exactly 2-cycle delay. During rst_n=0 both outputs are 1.
- Assert rst_n=0 for one cycle mid-stream, mid-blink → blink_phase and frame_cnt return to 0, and RGB is 000 for the next 2 cycles.
